// File: rtl/hat_man_sprite_ctrl_if.sv
// rtl/hat_man_sprite_ctrl_if.sv - pixel bus between VGA timing, Hat_man sprite controller and sprite ROM
interface hat_man_sprite_ctrl_if #(
  parameter int ADDR_W = 15
);
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic [ADDR_W-1:0] rom_address;
  logic              sprite_on;

  modport master (output DrawX, output DrawY, input rom_address, input sprite_on);
  modport slave  (input DrawX, input DrawY, output rom_address, output sprite_on);
endinterface

// File: rtl/hat_man_sprite_ctrl.sv
// rtl/hat_man_sprite_ctrl.sv - Hat_man sprite motion, walk-cycle FSM and registered ROM addressing
// Define HAT_MAN_MIRROR_EN to draw the sprite horizontally mirrored while facing left.
module hat_man_sprite_ctrl #(
  parameter int SPR_W      = 70,
  parameter int SPR_H      = 70,
  parameter int NUM_FRAMES = 4,
  parameter int ANIM_DIV   = 8,
  parameter int STEP       = 2,
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int START_X    = 285,
  parameter int START_Y    = 205,
  parameter int ADDR_W     = 15,
  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic                   vga_clk,
  input  logic                   reset,
  hat_man_sprite_ctrl_if.slave   pix,
  input  logic                   enable,
  input  logic                   key_left,
  input  logic                   key_right,
  input  logic                   key_up,
  input  logic                   key_down,
  output logic [9:0]             pos_x,
  output logic [9:0]             pos_y,
  output logic [FW-1:0]          frame_idx,
  output logic                   facing_left,
  output logic [1:0]             walk_state
);

  localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic signed [10:0] MAX_X  = 11'(SCREEN_W - SPR_W);
  localparam logic signed [10:0] MAX_Y  = 11'(SCREEN_H - SPR_H);

  typedef enum logic [1:0] {STAND = 2'b00, WALK = 2'b01, BLOCKED = 2'b10} state_t;

  state_t            state_q, state_d;
  logic [9:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [FW-1:0]     frame_idx_q, frame_idx_d, frame_adv;
  logic [AW-1:0]     anim_cnt_q, anim_cnt_d, anim_adv;
  logic              facing_left_q, facing_left_d;
  logic              raw_q, raw_d;
  logic [ADDR_W-1:0] rom_address_q, rom_address_d;
  logic              sprite_on_q, sprite_on_d;

  logic              tick, requested, moved, in_box;
  logic signed [10:0] dx, dy, sum_x, sum_y;
  logic [9:0]        new_x, new_y, rel_x, rel_y, col;

  always_comb begin
    raw_d = (pix.DrawX == 10'(SCREEN_W - 1)) && (pix.DrawY == 10'(SCREEN_H - 1));
    tick  = raw_d && !raw_q;

    dx = 11'sd0;
    if (key_right && !key_left) dx = STEP_S;
    if (key_left && !key_right) dx = -STEP_S;
    dy = 11'sd0;
    if (key_down && !key_up) dy = STEP_S;
    if (key_up && !key_down) dy = -STEP_S;

    // Signed 11-bit sums so a step left of column 0 clamps instead of wrapping.
    sum_x = $signed({1'b0, pos_x_q}) + dx;
    sum_y = $signed({1'b0, pos_y_q}) + dy;
    if (sum_x < 0)          new_x = 10'd0;
    else if (sum_x > MAX_X) new_x = MAX_X[9:0];
    else                    new_x = sum_x[9:0];
    if (sum_y < 0)          new_y = 10'd0;
    else if (sum_y > MAX_Y) new_y = MAX_Y[9:0];
    else                    new_y = sum_y[9:0];

    requested = (dx != 11'sd0) || (dy != 11'sd0);
    moved     = (new_x != pos_x_q) || (new_y != pos_y_q);

    // Every walking tick is an animation step, including the one leaving STAND.
    if (anim_cnt_q == AW'(ANIM_DIV - 1)) begin
      anim_adv  = '0;
      frame_adv = (frame_idx_q == FW'(NUM_FRAMES - 1)) ? '0 : frame_idx_q + 1'b1;
    end else begin
      anim_adv  = anim_cnt_q + 1'b1;
      frame_adv = frame_idx_q;
    end

    state_d       = state_q;
    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    frame_idx_d   = frame_idx_q;
    anim_cnt_d    = anim_cnt_q;
    facing_left_d = facing_left_q;

    if (tick && enable) begin
      pos_x_d = new_x;
      pos_y_d = new_y;
      if (key_left && !key_right) facing_left_d = 1'b1;
      if (key_right && !key_left) facing_left_d = 1'b0;
      case (state_q)
        STAND: begin
          frame_idx_d = '0;
          anim_cnt_d  = '0;
          if (moved) begin
            state_d     = WALK;
            frame_idx_d = frame_adv;
            anim_cnt_d  = anim_adv;
          end else if (requested) begin
            state_d = BLOCKED;
          end
        end
        WALK: begin
          if (!requested) begin
            state_d     = STAND;
            frame_idx_d = '0;
            anim_cnt_d  = '0;
          end else if (!moved) begin
            state_d = BLOCKED;
          end else begin
            frame_idx_d = frame_adv;
            anim_cnt_d  = anim_adv;
          end
        end
        BLOCKED: begin
          if (moved) begin
            state_d     = WALK;
            frame_idx_d = frame_adv;
            anim_cnt_d  = anim_adv;
          end else if (!requested) begin
            state_d     = STAND;
            frame_idx_d = '0;
            anim_cnt_d  = '0;
          end
        end
        default: begin
          state_d     = STAND;
          frame_idx_d = '0;
          anim_cnt_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    in_box = ({1'b0, pix.DrawX} >= {1'b0, pos_x_q}) &&
             ({1'b0, pix.DrawX} <  {1'b0, pos_x_q} + 11'(SPR_W)) &&
             ({1'b0, pix.DrawY} >= {1'b0, pos_y_q}) &&
             ({1'b0, pix.DrawY} <  {1'b0, pos_y_q} + 11'(SPR_H));
    rel_x = pix.DrawX - pos_x_q;
    rel_y = pix.DrawY - pos_y_q;
`ifdef HAT_MAN_MIRROR_EN
    col = facing_left_q ? (10'(SPR_W - 1) - rel_x) : rel_x;
`else
    col = rel_x;
`endif
    sprite_on_d   = in_box;
    rom_address_d = '0;
    if (in_box) begin
      rom_address_d = ADDR_W'(frame_idx_q) * ADDR_W'(SPR_W * SPR_H)
                    + ADDR_W'(rel_y) * ADDR_W'(SPR_W)
                    + ADDR_W'(col);
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q       <= STAND;
      pos_x_q       <= 10'(START_X);
      pos_y_q       <= 10'(START_Y);
      frame_idx_q   <= '0;
      anim_cnt_q    <= '0;
      facing_left_q <= 1'b0;
      raw_q         <= 1'b0;
      rom_address_q <= '0;
      sprite_on_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      frame_idx_q   <= frame_idx_d;
      anim_cnt_q    <= anim_cnt_d;
      facing_left_q <= facing_left_d;
      raw_q         <= raw_d;
      rom_address_q <= rom_address_d;
      sprite_on_q   <= sprite_on_d;
    end
  end

  assign pix.rom_address = rom_address_q;
  assign pix.sprite_on   = sprite_on_q;
  assign pos_x           = pos_x_q;
  assign pos_y           = pos_y_q;
  assign frame_idx       = frame_idx_q;
  assign facing_left     = facing_left_q;
  assign walk_state      = state_q;

endmodule

// File: tb/tb_hat_man_sprite_ctrl.sv
// tb/tb_hat_man_sprite_ctrl.sv - table-driven bench for hat_man_sprite_ctrl
module tb_hat_man_sprite_ctrl;

  logic       vga_clk = 1'b0;
  logic       reset;
  logic       enable, key_left, key_right, key_up, key_down;
  logic [9:0] pos_x, pos_y;
  logic [1:0] frame_idx;
  logic       facing_left;
  logic [1:0] walk_state;

  int checks = 0;
  int errors = 0;

  always #5 vga_clk = ~vga_clk;

  hat_man_sprite_ctrl_if #(.ADDR_W(15)) pix ();

  hat_man_sprite_ctrl dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .pix         (pix),
    .enable      (enable),
    .key_left    (key_left),
    .key_right   (key_right),
    .key_up      (key_up),
    .key_down    (key_down),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .frame_idx   (frame_idx),
    .facing_left (facing_left),
    .walk_state  (walk_state)
  );

  typedef struct {
    logic l, r, u, d, en;
    int   x, y, f, face, st;
  } tvec_t;

  typedef struct {
    int dx, dy, on, addr;
  } pvec_t;

  tvec_t tv[16];
  pvec_t pv[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic do_tick();
    pix.DrawX = 10'd639;
    pix.DrawY = 10'd479;
    cyc();
    pix.DrawX = 10'd0;
    pix.DrawY = 10'd0;
    cyc();
  endtask

  task automatic keys(input logic l, input logic r, input logic u, input logic d);
    key_left = l; key_right = r; key_up = u; key_down = d;
  endtask

  task automatic chk_state(input string name, input int x, input int y, input int f,
                           input int face, input int st);
    chk({name, ".pos_x"}, 32'(pos_x), x);
    chk({name, ".pos_y"}, 32'(pos_y), y);
    chk({name, ".frame_idx"}, 32'(frame_idx), f);
    chk({name, ".facing_left"}, 32'(facing_left), face);
    chk({name, ".walk_state"}, 32'(walk_state), st);
  endtask

  task automatic chk_pix(input string name, input int x, input int y, input int on, input int addr);
    pix.DrawX = 10'(x);
    pix.DrawY = 10'(y);
    cyc();
    chk({name, ".sprite_on"}, 32'(pix.sprite_on), on);
    chk({name, ".rom_address"}, 32'(pix.rom_address), addr);
  endtask

  initial begin
    //            l     r     u     d     en    x    y    f  face st
    tv[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 287, 205, 0, 0, 1};
    tv[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 289, 205, 0, 0, 1};
    tv[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 291, 205, 0, 0, 1};
    tv[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 293, 205, 0, 0, 1};
    tv[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 295, 205, 0, 0, 1};
    tv[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 297, 205, 0, 0, 1};
    tv[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 299, 205, 0, 0, 1};
    tv[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 301, 205, 1, 0, 1};
    tv[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 301, 205, 0, 0, 0};
    tv[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 299, 205, 0, 1, 1};
    tv[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 299, 203, 0, 1, 1};
    tv[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 299, 203, 0, 1, 0};
    tv[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 299, 203, 0, 1, 0};
    tv[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 297, 203, 0, 1, 1};
    tv[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 297, 203, 0, 1, 1};
    tv[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 299, 205, 0, 0, 1};

    // Sprite box at reset: x 285..354, y 205..274, frame 0.
    pv[0] = '{295, 215, 1, 710};
    pv[1] = '{285, 205, 1, 0};
    pv[2] = '{286, 206, 1, 71};
    pv[3] = '{354, 274, 1, 4899};
    pv[4] = '{355, 274, 0, 0};
    pv[5] = '{284, 215, 0, 0};
    pv[6] = '{300, 275, 0, 0};
    pv[7] = '{300, 204, 0, 0};
    pv[8] = '{700, 215, 0, 0};

    reset = 1'b1;
    enable = 1'b1;
    keys(1'b0, 1'b0, 1'b0, 1'b0);
    pix.DrawX = 10'd0;
    pix.DrawY = 10'd0;
    cyc();
    cyc();
    chk_state("reset", 285, 205, 0, 0, 0);
    chk("reset.sprite_on", 32'(pix.sprite_on), 0);
    chk("reset.rom_address", 32'(pix.rom_address), 0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++)
      chk_pix($sformatf("pix%0d", i), pv[i].dx, pv[i].dy, pv[i].on, pv[i].addr);

    for (int i = 0; i < 16; i++) begin
      keys(tv[i].l, tv[i].r, tv[i].u, tv[i].d);
      enable = tv[i].en;
      do_tick();
      chk_state($sformatf("tick%0d", i), tv[i].x, tv[i].y, tv[i].f, tv[i].face, tv[i].st);
    end

    // Coordinates stalled on the last visible pixel: a single tick only.
    keys(1'b0, 1'b1, 1'b0, 1'b0);
    enable = 1'b1;
    pix.DrawX = 10'd639;
    pix.DrawY = 10'd479;
    for (int i = 0; i < 5; i++) cyc();
    pix.DrawX = 10'd0;
    pix.DrawY = 10'd0;
    cyc();
    chk("stall.pos_x", 32'(pos_x), 301);

    // Reset during WALK, with a tick presented on the same edge.
    pix.DrawX = 10'd639;
    pix.DrawY = 10'd479;
    reset = 1'b1;
    cyc();
    pix.DrawX = 10'd0;
    pix.DrawY = 10'd0;
    chk_state("midreset", 285, 205, 0, 0, 0);
    reset = 1'b0;

    // Walk to the right edge: 285 -> 569 in 142 ticks, then clamp at 570.
    keys(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 142; i++) do_tick();
    chk_state("right569", 569, 205, 1, 0, 1);
    do_tick();
    chk_state("right570", 570, 205, 1, 0, 1);
    do_tick();
    chk_state("blocked1", 570, 205, 1, 0, 2);
    do_tick();
    chk_state("blocked2", 570, 205, 1, 0, 2);
    chk_pix("edge_px", 580, 215, 1, 5610);
    chk_pix("edge_corner", 639, 274, 1, 9799);
    keys(1'b1, 1'b1, 1'b0, 1'b0);
    do_tick();
    chk_state("cancel", 570, 205, 0, 0, 0);

    keys(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) do_tick();
    chk_state("left8", 554, 205, 1, 1, 1);
`ifdef HAT_MAN_MIRROR_EN
    chk_pix("mirror_px", 564, 215, 1, 5659);
`else
    chk_pix("mirror_px", 564, 215, 1, 5610);
`endif
    chk_pix("out_px", 624, 215, 0, 0);

    // Top edge: 205 -> 1 in 102 ticks, clamp to 0, then BLOCKED.
    keys(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 103; i++) do_tick();
    chk("top.pos_y", 32'(pos_y), 0);
    chk("top.walk_state", 32'(walk_state), 1);
    do_tick();
    chk_state("top_blocked", 554, 0, frame_idx, 1, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hat_man_sprite_ctrl.md
Name: hat_man_sprite_ctrl

Overview:
Motion and animation controller for the Hat_man walking sprite.
- Samples player direction keys once per video frame and moves the sprite inside the visible area with clamping.
- Sequences the walk-cycle frames with a small state machine.
- Produces, per pixel, the registered sprite ROM address and a sprite-hit flag.
- Sits between the VGA timing generator (DrawX/DrawY) and the sprite ROM/palette pair; the colour mapper uses sprite_on to choose sprite over background.

Parameters:
SPR_W, 70, sprite width in pixels
SPR_H, 70, sprite height in pixels
NUM_FRAMES, 4, walk-cycle frames stacked in ROM; frame f base = f*SPR_W*SPR_H
ANIM_DIV, 8, video frames per animation step
STEP, 2, pixels moved per video frame
SCREEN_W, 640, visible width
SCREEN_H, 480, visible height
START_X, 285, reset x position (top-left corner)
START_Y, 205, reset y position
ADDR_W, 15, ROM address width (must cover NUM_FRAMES*SPR_W*SPR_H)

Ports:
vga_clk  in  1  pixel clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
DrawX  in  10  current pixel column
DrawY  in  10  current pixel row
enable  in  1  1 = motion/animation allowed; 0 = freeze position and animation
key_left  in  1  level, move left
key_right  in  1  level, move right
key_up  in  1  level, move up
key_down  in  1  level, move down
rom_address  out  ADDR_W  sprite ROM address for the pixel presented last cycle
sprite_on  out  1  pixel presented last cycle lies inside the sprite box
pos_x  out  10  sprite top-left x
pos_y  out  10  sprite top-left y
frame_idx  out  $clog2(NUM_FRAMES)  current animation frame
facing_left  out  1  last horizontal direction was left
walk_state  out  2  00 STAND, 01 WALK, 10 BLOCKED

Behaviour:
- Reset is synchronous and active-high, on vga_clk; it is the only reset.
- Reset values: pos_x=START_X, pos_y=START_Y, frame_idx=0, anim_cnt=0, facing_left=0, state STAND, rom_address=0, sprite_on=0, tick detector cleared.
- Frame tick:
  - raw = (DrawX==SCREEN_W-1 && DrawY==SCREEN_H-1).
  - frame_tick = raw && !raw_d, where raw_d is raw registered.
  - Exactly one tick per frame even if the coordinates stall.
  - All motion/FSM updates occur only on the cycle frame_tick=1 and enable=1, so position never changes mid visible frame (no tearing).
- Net move:
  - dx = STEP*(key_right - key_left); dy = STEP*(key_down - key_up). Opposing keys cancel.
  - New x = clamp(pos_x+dx, 0, SCREEN_W-SPR_W), computed in 11-bit signed arithmetic so there is no wrap-around below 0. Same for y with SCREEN_H-SPR_H.
- Facing:
  - key_left alone sets facing_left=1; key_right alone clears it.
  - Both or neither leaves it unchanged.
- FSM (evaluated at tick):
  - requested = (dx!=0 || dy!=0); moved = (new pos != old pos).
  - STAND: moved → WALK; requested && !moved → BLOCKED; else stay. frame_idx=0, anim_cnt=0 while in STAND.
  - WALK: !requested → STAND (frame_idx←0, anim_cnt←0); requested && !moved → BLOCKED; else anim_cnt++. When anim_cnt==ANIM_DIV-1, anim_cnt←0 and frame_idx←(frame_idx+1) mod NUM_FRAMES.
  - BLOCKED: frame_idx and anim_cnt frozen. moved → WALK; !requested → STAND (clears frame/anim).
- enable=0: ticks are ignored and all state holds. Pixel addressing continues.
- Pixel path, 1-cycle latency, registered:
  - in_box = DrawX in [pos_x, pos_x+SPR_W) and DrawY in [pos_y, pos_y+SPR_H).
  - If in_box: rom_address = frame_idx*SPR_W*SPR_H + (DrawY-pos_y)*SPR_W + (DrawX-pos_x), and sprite_on=1.
  - Otherwise rom_address=0 and sprite_on=0.
  - Pixel addressing uses pos/frame values before any same-cycle tick update.
- DrawX/DrawY outside the visible range (blanking) give sprite_on=0 unless inside the box. The clamp guarantees the box is always fully visible.
- Reset asserted mid-walk takes effect on the next posedge, regardless of tick or enable.

Optional Feature:
HAT_MAN_MIRROR_EN:
- When defined and facing_left=1, the column term becomes (SPR_W-1-(DrawX-pos_x)), so the sprite is drawn horizontally mirrored.
- When not defined, facing_left is still output but never affects rom_address.

Test Plan:
- Reset → pos=(285,205), frame_idx=0, walk_state=STAND, sprite_on=0, rom_address=0 one cycle after reset.
- key_right held over 3 ticks → pos_x 291, facing_left=0, WALK. Hold through 8 ticks total → frame_idx=1 after the 8th tick. Release → STAND, frame_idx=0 on next tick.
- pos_x=568 with key_right held → 570 after first tick (WALK), unchanged on second tick, BLOCKED with frame_idx frozen. Add key_left with key_right → requested=0 → STAND.
- pos=(100,50), frame_idx=1, DrawX=110, DrawY=60 → next cycle rom_address=5610, sprite_on=1. DrawX=170 → sprite_on=0, rom_address=0.
- Same as previous with facing_left=1 and HAT_MAN_MIRROR_EN defined → rom_address=5659. Without the macro → 5610.
- DrawX/DrawY held at (639,479) for 5 cycles → exactly one tick. enable=0 with keys held → no position change. Reset pulsed mid-WALK → all reset values next cycle.
